// File: rtl/adder_bist_if.sv
// Operand/result bus between the BIST controller and the 4-bit adder under test.
interface adder_bist_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic [3:0] SUM;
    logic       cout;

    // BIST side: drives operands, observes the adder result.
    modport master (
        output A,
        output B,
        output cin,
        input  SUM,
        input  cout
    );

    // Adder side: consumes operands, returns the result.
    modport slave (
        input  A,
        input  B,
        input  cin,
        output SUM,
        output cout
    );
endinterface

// File: rtl/adder_bist.sv
// Exhaustive built-in self test for a 4-bit adder: walks all 512 {cin,A,B}
// vectors, lets each settle, checks {cout,SUM} and records the failure count
// and the first failing vector.
module adder_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    adder_bist_if.master aut,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [9:0]   err_count,
    output logic [8:0]   fail_vec,
    output logic         fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [8:0] IDX_LAST    = 9'd511;

    state_t     state_q, state_n;
    logic [8:0] idx_q, idx_n;
    logic [3:0] cnt_q, cnt_n;
    logic [9:0] err_q, err_n;
    logic [8:0] fvec_q, fvec_n;
    logic       fvalid_q, fvalid_n;

    logic [4:0] expected;
    logic       mismatch;

    // Operands come straight from the registered vector index.
    assign aut.cin = idx_q[8];
    assign aut.A   = idx_q[7:4];
    assign aut.B   = idx_q[3:0];

    assign busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvalid_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Vector index, settle counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
        end else begin
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            err_q    <= err_n;
            fvec_q   <= fvec_n;
            fvalid_q <= fvalid_n;
        end
    end

    // Next-state and datapath update; the reference sum is formed from idx.
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        err_n    = err_q;
        fvec_n   = fvec_q;
        fvalid_n = fvalid_q;

        expected = {1'b0, idx_q[7:4]} + {1'b0, idx_q[3:0]} + {4'b0000, idx_q[8]};
        mismatch = ({aut.cout, aut.SUM} != expected);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = SETTLE;
                    idx_n    = '0;
                    cnt_n    = '0;
                    err_n    = '0;
                    fvec_n   = '0;
                    fvalid_n = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                cnt_n = '0;
                if (mismatch) begin
                    err_n = err_q + 10'd1;
                    if (!fvalid_q) begin
                        fvec_n   = idx_q;
                        fvalid_n = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx_q + 9'd1;
                    state_n = SETTLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: a behavioural adder (optionally faulty)
// sits on the bus, and a whole-run reference model predicts the BIST result.
module tb_adder_bist;

    logic clk;
    logic rst;
    logic start0, start1;

    logic       busy0, done0, pass0, fvalid0;
    logic [9:0] err0;
    logic [8:0] fvec0;
    logic       busy1, done1, pass1, fvalid1;
    logic [9:0] err1;
    logic [8:0] fvec1;

    int checks;
    int failures;

    // Fault mode of the adder on bus0: 0 good, 1 SUM[0] stuck-0, 2 cout stuck-1, 3 random corruption.
    int         mode0;
    logic [4:0] corrupt [512];

    adder_bist_if bus0 ();
    adder_bist_if bus1 ();

    logic [8:0] vec0, vec1;
    assign vec0 = {bus0.cin, bus0.A, bus0.B};
    assign vec1 = {bus1.cin, bus1.A, bus1.B};

    adder_bist #(.SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .aut(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vec(fvec0), .fail_valid(fvalid0)
    );

    adder_bist #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .aut(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fvec1), .fail_valid(fvalid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] true_sum(input logic [8:0] v);
        int s;
        s = int'(v[7:4]) + int'(v[3:0]) + int'(v[8]);
        return 5'(s);
    endfunction

    function automatic logic [4:0] adder_out(input int mode, input logic [4:0] mask, input logic [8:0] v);
        logic [4:0] t;
        t = true_sum(v);
        case (mode)
            1:       return t & 5'b11110;
            2:       return t | 5'b10000;
            3:       return t ^ mask;
            default: return t;
        endcase
    endfunction

    // Behavioural adders attached to the two BIST instances.
    always_comb {bus0.cout, bus0.SUM} = adder_out(mode0, corrupt[vec0], vec0);
    always_comb {bus1.cout, bus1.SUM} = adder_out(0, 5'b00000, vec1);

    // Whole-run prediction: count faulty vectors in ascending order, note the first.
    task automatic compute_ref(input int mode, output int e_err, output int e_fv, output bit e_fvalid);
        e_err = 0; e_fv = 0; e_fvalid = 1'b0;
        for (int v = 0; v < 512; v++) begin
            if (adder_out(mode, corrupt[v], 9'(v)) != true_sum(9'(v))) begin
                if (!e_fvalid) begin
                    e_fv = v;
                    e_fvalid = 1'b1;
                end
                e_err++;
            end
        end
    endtask

    // Pulse start0, optionally re-pulse during the run, and count cycles to done.
    task automatic run0(input int restart_at, output int lat, output int busy_bad, output logic [12:0] first);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        lat = 0; busy_bad = 0;
        first = {done0, busy0, fvalid0, err0};
        while (done0 !== 1'b1 && lat < 5000) begin
            if (busy0 !== 1'b1) busy_bad++;
            if (lat == restart_at) start0 = 1'b1;
            @(posedge clk); #1 start0 = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset;
        logic [25:0] obs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs = {bus0.A, bus0.B, bus0.cin, busy0, done0, pass0, err0, fvec0, fvalid0} & 26'h3ffffff;
        checks++;
        if ({bus0.A, bus0.B, bus0.cin} !== 9'h000) begin
            failures++; $display("FAIL reset_operands0: got %h expected 000", vec0);
        end
        checks++;
        if ({busy0, done0, pass0, fvalid0} !== 4'b0000 || err0 !== 10'd0 || fvec0 !== 9'd0) begin
            failures++; $display("FAIL reset_status0: got %h expected 0", obs);
        end
        checks++;
        if ({vec1, busy1, done1, pass1, fvalid1, err1, fvec1} !== '0) begin
            failures++; $display("FAIL reset_u1: got %h expected 0", {vec1, busy1, done1, pass1, fvalid1, err1, fvec1});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy0, done0);
        end
    endtask

    task automatic test_fault_runs;
        int modes [6] = '{0, 1, 2, 3, 3, 3};
        int lat, busy_bad, e_err, e_fv;
        bit e_fvalid;
        logic [12:0] first;
        for (int i = 0; i < 6; i++) begin
            if (modes[i] == 3) begin
                for (int v = 0; v < 512; v++)
                    corrupt[v] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            end
            mode0 = modes[i];
            compute_ref(mode0, e_err, e_fv, e_fvalid);
            run0(-1, lat, busy_bad, first);
            checks++;
            if (lat != 1536) begin
                failures++; $display("FAIL latency_mode%0d: got %0d expected 1536", mode0, lat);
            end
            checks++;
            if (busy_bad != 0 || busy0 !== 1'b0) begin
                failures++; $display("FAIL busy_mode%0d: got %0d low cycles, busy=%b expected 0, 0", mode0, busy_bad, busy0);
            end
            checks++;
            if (err0 !== 10'(e_err)) begin
                failures++; $display("FAIL err_count_mode%0d: got %0d expected %0d", mode0, err0, e_err);
            end
            checks++;
            if (fvalid0 !== e_fvalid || (e_fvalid && fvec0 !== 9'(e_fv))) begin
                failures++; $display("FAIL fail_vec_mode%0d: got %b/%h expected %b/%h", mode0, fvalid0, fvec0, e_fvalid, 9'(e_fv));
            end
            checks++;
            if (pass0 !== (e_err == 0) || done0 !== 1'b1) begin
                failures++; $display("FAIL pass_mode%0d: got pass=%b done=%b expected %b 1", mode0, pass0, done0, e_err == 0);
            end
            checks++;
            if (vec0 !== 9'h1ff) begin
                failures++; $display("FAIL operand_hold_mode%0d: got %h expected 1ff", mode0, vec0);
            end
            if (mode0 == 1) begin
                checks++;
                if (err0 !== 10'd256 || fvec0 !== 9'h001) begin
                    failures++; $display("FAIL sum0_stuck: got err=%0d vec=%h expected 256 001", err0, fvec0);
                end
            end
            if (mode0 == 2) begin
                checks++;
                if (err0 !== 10'd256 || fvec0 !== 9'h000) begin
                    failures++; $display("FAIL cout_stuck: got err=%0d vec=%h expected 256 000", err0, fvec0);
                end
            end
        end
    endtask

    task automatic test_reset_midrun;
        int n, lat, busy_bad;
        logic [12:0] first;
        mode0 = 1;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0;
        while (vec0 !== 9'd100 && n < 2000) begin
            @(posedge clk); #1 n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++; $display("FAIL reach_idx100: got timeout expected idx 100");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vec0, busy0, done0, pass0, fvalid0, err0, fvec0} !== '0) begin
            failures++; $display("FAIL async_reset_midrun: got %h expected 0", {vec0, busy0, done0, pass0, fvalid0, err0, fvec0});
        end
        @(posedge clk); #1 rst = 1'b0;
        mode0 = 0;
        run0(-1, lat, busy_bad, first);
        checks++;
        if (lat != 1536 || pass0 !== 1'b1 || err0 !== 10'd0 || fvalid0 !== 1'b0) begin
            failures++; $display("FAIL run_after_reset: got lat=%0d pass=%b err=%0d fv=%b expected 1536 1 0 0", lat, pass0, err0, fvalid0);
        end
    endtask

    task automatic test_start_while_busy;
        int lat, busy_bad, at;
        logic [12:0] first;
        mode0 = 0;
        at = $urandom_range(1, 1500);
        run0(at, lat, busy_bad, first);
        checks++;
        if (lat != 1536 || busy_bad != 0 || pass0 !== 1'b1) begin
            failures++; $display("FAIL start_while_busy_at%0d: got lat=%0d busy_low=%0d pass=%b expected 1536 0 1", at, lat, busy_bad, pass0);
        end
    endtask

    task automatic test_restart_in_done;
        int lat, busy_bad;
        logic [12:0] first;
        mode0 = 1;
        run0(-1, lat, busy_bad, first);
        mode0 = 0;
        run0(-1, lat, busy_bad, first);
        checks++;
        if (first !== {1'b0, 1'b1, 1'b0, 10'd0}) begin
            failures++; $display("FAIL restart_first_cycle: got done,busy,fv,err=%h expected %h", first, {1'b0, 1'b1, 1'b0, 10'd0});
        end
        checks++;
        if (lat != 1536 || pass0 !== 1'b1 || err0 !== 10'd0) begin
            failures++; $display("FAIL restart_run: got lat=%0d pass=%b err=%0d expected 1536 1 0", lat, pass0, err0);
        end
    endtask

    task automatic test_settle1;
        int lat, bad, first_bad_k;
        logic [8:0] want;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        lat = 0; bad = 0; first_bad_k = -1;
        while (done1 !== 1'b1 && lat < 5000) begin
            want = 9'(lat / 2);
            if (vec1 !== want) begin
                if (bad == 0) first_bad_k = lat;
                bad++;
            end
            @(posedge clk); #1 lat++;
        end
        checks++;
        if (lat != 1024) begin
            failures++; $display("FAIL settle1_latency: got %0d expected 1024", lat);
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL settle1_operand_timing: got %0d wrong cycles (first at %0d) expected 0", bad, first_bad_k);
        end
        checks++;
        if (pass1 !== 1'b1 || err1 !== 10'd0 || fvalid1 !== 1'b0 || vec1 !== 9'h1ff) begin
            failures++; $display("FAIL settle1_result: got pass=%b err=%0d fv=%b vec=%h expected 1 0 0 1ff", pass1, err1, fvalid1, vec1);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0 = 0;
        for (int v = 0; v < 512; v++) corrupt[v] = 5'd0;
        test_reset;
        test_fault_runs;
        test_reset_midrun;
        test_start_while_busy;
        test_restart_in_done;
        test_settle1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
